ysyx_25040111_csr_trap: RTL and testbench

YSYX_25040111_CSR_TRAP -- requirements
Module: ysyx_25040111_csr_trap

---
 rtl/ysyx_25040111_csr_pkg.sv | 36 +++
 rtl/ysyx_25040111_csr_counter64.sv | 32 +++
 rtl/ysyx_25040111_csr_trap.sv | 163 ++++++++++++++++
 tb/tb_ysyx_25040111_csr_trap.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040111_csr_pkg.sv
// Shared constants for the machine-mode CSR/trap block: CSR addresses, operation
// encodings, mstatus/mie bit positions and exception cause codes.
package ysyx_25040111_csr_pkg;

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_e;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MTIE     = 7;
   localparam int MIP_MTIP     = 7;

   localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
   localparam logic [3:0] CAUSE_MTI     = 4'd7;

   localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

endpackage

// File: rtl/ysyx_25040111_csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes.
// A half write wins over the increment for that cycle; the untouched half holds.
module ysyx_25040111_csr_counter64 (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc_i,
   input  logic        wr_lo_i,
   input  logic        wr_hi_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] cnt_o
);

   logic [63:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (wr_lo_i || wr_hi_i) begin
         if (wr_lo_i) cnt_d[31:0]  = wdata_i;
         if (wr_hi_i) cnt_d[63:32] = wdata_i;
      end else if (inc_i) begin
         cnt_d = cnt_q + 64'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_25040111_csr_trap.sv
// Machine-mode CSR file with synchronous trap entry, timer interrupt and mret.
// CSR reads and redirect are combinational; all state commits at posedge clk.
module ysyx_25040111_csr_trap
   import ysyx_25040111_csr_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter logic [31:0] VENDOR_ID = 32'h79737978,
   parameter logic [31:0] ARCH_ID   = 32'd25040111
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            csr_valid_i,
   input  logic [1:0]      csr_op_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   output logic [XLEN-1:0] csr_rdata_o,
   output logic            csr_illegal_o,
   input  logic            trap_valid_i,
   input  logic [3:0]      trap_cause_i,
   input  logic [XLEN-1:0] cur_pc_i,
   input  logic            mret_i,
   input  logic            instret_i,
   input  logic            timer_irq_i,
   output logic            irq_take_o,
   output logic            redirect_o,
   output logic [XLEN-1:0] redirect_pc_o
);

   csr_op_e     op;
   logic        mie_q, mie_d, mpie_q, mpie_d, mtie_q, mtie_d;
   logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
   logic [31:0] mstatus_rd, mip_rd, rd_val, wval, base;
   logic [63:0] mcycle, minstret;
   logic        known, read_only, is_write, csr_wr, trap_enter;

   assign op = csr_op_e'(csr_op_i);

   always_comb begin
      mstatus_rd               = MSTATUS_RST;
      mstatus_rd[MSTATUS_MIE]  = mie_q;
      mstatus_rd[MSTATUS_MPIE] = mpie_q;
      mip_rd                   = '0;
      mip_rd[MIP_MTIP]         = timer_irq_i;
   end

   always_comb begin
      known     = 1'b1;
      read_only = 1'b0;
      rd_val    = '0;
      case (csr_addr_i)
         CSR_MSTATUS:   rd_val = mstatus_rd;
         CSR_MIE:       rd_val = {24'd0, mtie_q, 7'd0};
         CSR_MTVEC:     rd_val = mtvec_q;
         CSR_MSCRATCH:  rd_val = mscratch_q;
         CSR_MEPC:      rd_val = mepc_q;
         CSR_MCAUSE:    rd_val = mcause_q;
         CSR_MIP:       begin rd_val = mip_rd;    read_only = 1'b1; end
         CSR_MCYCLE:    rd_val = mcycle[31:0];
         CSR_MCYCLEH:   rd_val = mcycle[63:32];
         CSR_MINSTRET:  rd_val = minstret[31:0];
         CSR_MINSTRETH: rd_val = minstret[63:32];
         CSR_MVENDORID: begin rd_val = VENDOR_ID; read_only = 1'b1; end
         CSR_MARCHID:   begin rd_val = ARCH_ID;   read_only = 1'b1; end
         default:       known = 1'b0;
      endcase
   end

   // Set/clear with a zero mask is a pure read, so it stays legal on read-only CSRs.
   always_comb begin
      wval     = rd_val;
      is_write = 1'b0;
      case (op)
         CSR_OP_RW: begin wval = csr_wdata_i;           is_write = 1'b1; end
         CSR_OP_RS: begin wval = rd_val | csr_wdata_i;  is_write = |csr_wdata_i; end
         CSR_OP_RC: begin wval = rd_val & ~csr_wdata_i; is_write = |csr_wdata_i; end
         default:   ;
      endcase
   end

   assign csr_rdata_o   = (csr_valid_i && known) ? rd_val : '0;
   assign csr_illegal_o = csr_valid_i && (!known || (read_only && is_write));

   assign irq_take_o = mie_q & mtie_q & timer_irq_i & ~trap_valid_i & ~mret_i & ~reset;
   assign trap_enter = trap_valid_i | irq_take_o;
   assign csr_wr     = csr_valid_i & is_write & ~csr_illegal_o & ~trap_enter & ~mret_i;

   assign base          = {mtvec_q[31:2], 2'b00};
   assign redirect_o    = ~reset & (trap_valid_i | irq_take_o | mret_i);
   assign redirect_pc_o = trap_valid_i ? base :
                          irq_take_o   ? (mtvec_q[0] ? base + 32'd28 : base) :
                                         mepc_q;

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtie_d     = mtie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      if (trap_enter) begin
         mepc_d   = cur_pc_i & ~32'h3;
         mcause_d = {irq_take_o, 27'd0, trap_valid_i ? trap_cause_i : CAUSE_MTI};
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (mret_i) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (csr_wr) begin
         case (csr_addr_i)
            CSR_MSTATUS:  begin mie_d = wval[MSTATUS_MIE]; mpie_d = wval[MSTATUS_MPIE]; end
            CSR_MIE:      mtie_d = wval[MIE_MTIE];
            CSR_MTVEC:    mtvec_d = {wval[31:2], 1'b0, wval[1:0] == 2'b01};
            CSR_MSCRATCH: mscratch_d = wval;
            CSR_MEPC:     mepc_d = wval & ~32'h3;
            CSR_MCAUSE:   mcause_d = wval;
            default:      ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtie_q     <= 1'b0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtie_q     <= mtie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
      end
   end

   ysyx_25040111_csr_counter64 u_mcycle (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (1'b1),
      .wr_lo_i (csr_wr && csr_addr_i == CSR_MCYCLE),
      .wr_hi_i (csr_wr && csr_addr_i == CSR_MCYCLEH),
      .wdata_i (wval),
      .cnt_o   (mcycle)
   );

   ysyx_25040111_csr_counter64 u_minstret (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (instret_i),
      .wr_lo_i (csr_wr && csr_addr_i == CSR_MINSTRET),
      .wr_hi_i (csr_wr && csr_addr_i == CSR_MINSTRETH),
      .wdata_i (wval),
      .cnt_o   (minstret)
   );

endmodule

// File: tb/tb_ysyx_25040111_csr_trap.sv
// Directed bench for the CSR/trap block: inputs change on negedge, outputs are
// sampled 1ns later, state is read back through CSR reads after the posedge.
module tb_ysyx_25040111_csr_trap;
   import ysyx_25040111_csr_pkg::*;

   logic        clk;
   logic        reset;
   logic        csr_valid;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        trap_valid;
   logic [3:0]  trap_cause;
   logic [31:0] cur_pc;
   logic        mret;
   logic        instret;
   logic        timer_irq;
   logic        irq_take;
   logic        redirect;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   ysyx_25040111_csr_trap dut (
      .clk           (clk),
      .reset         (reset),
      .csr_valid_i   (csr_valid),
      .csr_op_i      (csr_op),
      .csr_addr_i    (csr_addr),
      .csr_wdata_i   (csr_wdata),
      .csr_rdata_o   (csr_rdata),
      .csr_illegal_o (csr_illegal),
      .trap_valid_i  (trap_valid),
      .trap_cause_i  (trap_cause),
      .cur_pc_i      (cur_pc),
      .mret_i        (mret),
      .instret_i     (instret),
      .timer_irq_i   (timer_irq),
      .irq_take_o    (irq_take),
      .redirect_o    (redirect),
      .redirect_pc_o (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      csr_valid  = 1'b0;
      csr_op     = 2'b00;
      csr_addr   = 12'h000;
      csr_wdata  = 32'h0;
      trap_valid = 1'b0;
      trap_cause = 4'h0;
      cur_pc     = 32'h0;
      mret       = 1'b0;
      instret    = 1'b0;
      timer_irq  = 1'b0;
   endtask

   // Drives one CSR access for the coming posedge; outputs valid on return.
   task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      clr();
      csr_valid = 1'b1;
      csr_op    = op;
      csr_addr  = a;
      csr_wdata = d;
      #1;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
      csr(CSR_OP_RS, a, 32'h0);
      chk(tag, csr_rdata, exp);
   endtask

   initial begin
      reset = 1'b1;
      clr();

      // Reset: reads still reflect registers, trap and irq are overridden.
      rd(CSR_MSTATUS, 32'h0000_1800, "rst_mstatus");
      @(negedge clk);
      clr();
      trap_valid = 1'b1;
      trap_cause = 4'd11;
      cur_pc     = 32'h0000_1234;
      #1;
      chk("rst_redirect", {31'd0, redirect}, 32'd0);
      chk("rst_irq_take", {31'd0, irq_take}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      clr();

      rd(CSR_MEPC,      32'h0,         "rst_trap_dropped_mepc");
      rd(CSR_MSTATUS,   32'h0000_1800, "mstatus_after_rst");
      rd(CSR_MVENDORID, 32'h7973_7978, "mvendorid");
      rd(CSR_MARCHID,   32'd25040111,  "marchid");
      rd(CSR_MCAUSE,    32'h0,         "mcause_rst");

      // Synchronous exception into a vectored mtvec still uses the base.
      csr(CSR_OP_RW, CSR_MTVEC, 32'h8000_0001);
      chk("mtvec_rw_illegal", {31'd0, csr_illegal}, 32'd0);
      rd(CSR_MTVEC, 32'h8000_0001, "mtvec_vectored");
      @(negedge clk);
      clr();
      trap_valid = 1'b1;
      trap_cause = CAUSE_ECALL_M;
      cur_pc     = 32'h8000_0100;
      #1;
      chk("ecall_redirect",    {31'd0, redirect}, 32'd1);
      chk("ecall_redirect_pc", redirect_pc,       32'h8000_0000);
      rd(CSR_MEPC,    32'h8000_0100, "ecall_mepc");
      rd(CSR_MCAUSE,  32'h0000_000B, "ecall_mcause");
      rd(CSR_MSTATUS, 32'h0000_1800, "ecall_mstatus");

      // Timer interrupt, vectored.
      csr(CSR_OP_RS, CSR_MSTATUS, 32'h0000_0008);
      rd(CSR_MSTATUS, 32'h0000_1808, "mstatus_mie_set");
      csr(CSR_OP_RS, CSR_MIE, 32'h0000_0080);
      rd(CSR_MIE, 32'h0000_0080, "mie_mtie_set");
      @(negedge clk);
      clr();
      timer_irq = 1'b1;
      cur_pc    = 32'h8000_0200;
      csr_valid = 1'b1;
      csr_op    = CSR_OP_RS;
      csr_addr  = CSR_MIP;
      #1;
      chk("irq_take",        {31'd0, irq_take}, 32'd1);
      chk("irq_redirect_pc", redirect_pc,       32'h8000_001C);
      chk("mip_mtip",        csr_rdata,         32'h0000_0080);
      chk("mip_read_legal",  {31'd0, csr_illegal}, 32'd0);
      @(negedge clk);
      clr();
      timer_irq = 1'b1;
      csr_valid = 1'b1;
      csr_op    = CSR_OP_RS;
      csr_addr  = CSR_MCAUSE;
      #1;
      chk("irq_mcause",      csr_rdata,         32'h8000_0007);
      chk("irq_masked_after",{31'd0, irq_take}, 32'd0);
      rd(CSR_MSTATUS, 32'h0000_1880, "irq_mstatus");
      rd(CSR_MEPC,    32'h8000_0200, "irq_mepc");

      // mret restores MIE from MPIE and returns to mepc.
      @(negedge clk);
      clr();
      mret = 1'b1;
      #1;
      chk("mret_redirect",    {31'd0, redirect}, 32'd1);
      chk("mret_redirect_pc", redirect_pc,       32'h8000_0200);
      rd(CSR_MSTATUS, 32'h0000_1888, "mret_mstatus");

      // mstatus write masking and zero-mask clear.
      csr(CSR_OP_RC, CSR_MSTATUS, 32'h0);
      chk("rc0_illegal", {31'd0, csr_illegal}, 32'd0);
      rd(CSR_MSTATUS, 32'h0000_1888, "rc0_no_change");
      csr(CSR_OP_RW, CSR_MSTATUS, 32'hFFFF_FFFF);
      rd(CSR_MSTATUS, 32'h0000_1888, "mstatus_mask");
      csr(CSR_OP_RW, CSR_MSTATUS, 32'h0);
      rd(CSR_MSTATUS, 32'h0000_1800, "mstatus_clear");
      csr(CSR_OP_RW, CSR_MTVEC, 32'h8000_0003);
      rd(CSR_MTVEC, 32'h8000_0000, "mtvec_mode_1x");
      csr(CSR_OP_RW, CSR_MEPC, 32'h1234_5677);
      rd(CSR_MEPC, 32'h1234_5674, "mepc_low_bits");

      // mcycle low-half wrap carries into the high half.
      rd(CSR_MCYCLEH, 32'h0, "mcycleh_start");
      csr(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
      rd(CSR_MCYCLE,  32'hFFFF_FFFF, "mcycle_written");
      rd(CSR_MCYCLE,  32'h0,         "mcycle_wrapped");
      rd(CSR_MCYCLEH, 32'h1,         "mcycleh_carry");
      csr(CSR_OP_RW, CSR_MCYCLE, 32'h0000_0010);
      csr(CSR_OP_RW, CSR_MCYCLEH, 32'h0000_0005);
      chk("mcycleh_prewrite", csr_rdata, 32'h1);
      rd(CSR_MCYCLE,  32'h0000_0010, "mcycle_hi_wr_no_inc");
      rd(CSR_MCYCLEH, 32'h0000_0005, "mcycleh_written");

      // minstret counts only retired instructions.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         clr();
         instret = 1'b1;
      end
      rd(CSR_MINSTRET, 32'd3, "minstret_count");
      csr(CSR_OP_RW, CSR_MINSTRETH, 32'h0000_0007);
      rd(CSR_MINSTRETH, 32'h0000_0007, "minstreth_written");

      // Read-only, unknown and idle accesses.
      csr(CSR_OP_RW, CSR_MVENDORID, 32'h0000_1234);
      chk("ro_write_illegal", {31'd0, csr_illegal}, 32'd1);
      chk("ro_write_rdata",   csr_rdata,            32'h7973_7978);
      rd(CSR_MVENDORID, 32'h7973_7978, "ro_unchanged");
      csr(CSR_OP_RS, CSR_MARCHID, 32'h0);
      chk("ro_rs0_legal", {31'd0, csr_illegal}, 32'd0);
      csr(CSR_OP_RW, 12'h7C0, 32'hFFFF_FFFF);
      chk("unknown_illegal", {31'd0, csr_illegal}, 32'd1);
      chk("unknown_rdata",   csr_rdata,            32'h0);
      @(negedge clk);
      clr();
      csr_addr = CSR_MSTATUS;
      #1;
      chk("idle_rdata",   csr_rdata,            32'h0);
      chk("idle_illegal", {31'd0, csr_illegal}, 32'd0);

      // A trap in the same cycle drops the CSR write.
      csr(CSR_OP_RW, CSR_MSCRATCH, 32'h0000_0055);
      rd(CSR_MSCRATCH, 32'h0000_0055, "mscratch_rw");
      @(negedge clk);
      clr();
      trap_valid = 1'b1;
      trap_cause = 4'd2;
      cur_pc     = 32'h8000_0300;
      csr_valid  = 1'b1;
      csr_op     = CSR_OP_RW;
      csr_addr   = CSR_MSCRATCH;
      csr_wdata  = 32'hDEAD_BEEF;
      #1;
      chk("trap_wr_rdata",       csr_rdata,   32'h0000_0055);
      chk("trap_wr_redirect_pc", redirect_pc, 32'h8000_0000);
      rd(CSR_MSCRATCH, 32'h0000_0055, "trap_wr_dropped");
      rd(CSR_MCAUSE,   32'h0000_0002, "trap_wr_mcause");

      // mret in the same cycle also drops the write.
      @(negedge clk);
      clr();
      mret      = 1'b1;
      csr_valid = 1'b1;
      csr_op    = CSR_OP_RW;
      csr_addr  = CSR_MSCRATCH;
      csr_wdata = 32'h0000_00AA;
      #1;
      chk("mret_wr_redirect_pc", redirect_pc, 32'h8000_0300);
      rd(CSR_MSCRATCH, 32'h0000_0055, "mret_wr_dropped");

      @(negedge clk);
      clr();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
